// File: rtl/fu_div_sched_if.sv
// rtl/fu_div_sched_if.sv - issue, divider and writeback signal bundle for fu_div_sched
interface fu_div_sched_if #(
    parameter int NREQ   = 4,
    parameter int TAG_W  = 4,
    parameter int DATA_W = 32
);
    logic [NREQ-1:0]        req_valid;
    logic [NREQ*DATA_W-1:0] req_a;
    logic [NREQ*DATA_W-1:0] req_b;
    logic [NREQ*TAG_W-1:0]  req_tag;
    logic [NREQ-1:0]        req_grant;
    logic                   div_en;
    logic [DATA_W-1:0]      div_a;
    logic [DATA_W-1:0]      div_b;
    logic [DATA_W-1:0]      div_res;
    logic                   div_finish;
    logic                   flush;
    logic                   wb_valid;
    logic [TAG_W-1:0]       wb_tag;
    logic [DATA_W-1:0]      wb_data;
    logic                   wb_ready;
    logic                   busy;

    modport master (
        output req_valid, req_a, req_b, req_tag, div_res, div_finish, flush, wb_ready,
        input  req_grant, div_en, div_a, div_b, wb_valid, wb_tag, wb_data, busy
    );

    modport slave (
        input  req_valid, req_a, req_b, req_tag, div_res, div_finish, flush, wb_ready,
        output req_grant, div_en, div_a, div_b, wb_valid, wb_tag, wb_data, busy
    );
endinterface

// File: rtl/fu_div_sched.sv
// rtl/fu_div_sched.sv - round-robin scheduler for the single multi-cycle divider FU_div
// Optional: DIV_ZERO_BYPASS_EN sends b==0 ops straight to writeback with an all-ones quotient.
module fu_div_sched #(
    parameter int NREQ   = 4,
    parameter int TAG_W  = 4,
    parameter int DATA_W = 32
) (
    input logic         clk,
    input logic         rst,
    fu_div_sched_if.slave bus
);
    localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_WB, S_DRAIN} state_t;

    state_t             state_q, state_d;
    logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [DATA_W-1:0]  a_q, a_d, b_q, b_d, wb_data_q, wb_data_d;
    logic [TAG_W-1:0]   tag_q, tag_d, wb_tag_q, wb_tag_d;
    logic [NREQ-1:0]    grant;
    logic               div_en, wb_valid, found;
    logic [PTR_W-1:0]   pick;
    logic [DATA_W-1:0]  pick_a, pick_b;
    logic [TAG_W-1:0]   pick_tag;

    function automatic logic [PTR_W-1:0] wrap_idx(input int v);
        return PTR_W'(v % NREQ);
    endfunction

    // First requester at or after rr_ptr, wrapping around.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (!found && bus.req_valid[wrap_idx(int'(rr_ptr_q) + k)]) begin
                found = 1'b1;
                pick  = wrap_idx(int'(rr_ptr_q) + k);
            end
        end
    end

    assign pick_a   = bus.req_a[pick*DATA_W +: DATA_W];
    assign pick_b   = bus.req_b[pick*DATA_W +: DATA_W];
    assign pick_tag = bus.req_tag[pick*TAG_W +: TAG_W];

    always_comb begin
        state_d   = state_q;
        rr_ptr_d  = rr_ptr_q;
        a_d       = a_q;
        b_d       = b_q;
        tag_d     = tag_q;
        wb_data_d = wb_data_q;
        wb_tag_d  = wb_tag_q;
        grant     = '0;
        div_en    = 1'b0;
        wb_valid  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (found && !bus.flush) begin
                    grant[pick] = 1'b1;
                    a_d         = pick_a;
                    b_d         = pick_b;
                    tag_d       = pick_tag;
                    rr_ptr_d    = (pick == PTR_W'(NREQ - 1)) ? '0 : pick + PTR_W'(1);
`ifdef DIV_ZERO_BYPASS_EN
                    if (pick_b == '0) begin
                        wb_data_d = '1;
                        wb_tag_d  = pick_tag;
                        state_d   = S_WB;
                    end else begin
                        state_d = S_ISSUE;
                    end
`else
                    state_d = S_ISSUE;
`endif
                end
            end
            S_ISSUE: begin
                div_en  = !bus.flush;
                state_d = bus.flush ? S_IDLE : S_WAIT;
            end
            S_WAIT: begin
                // A flushed op still occupies FU_div until its finish is seen.
                if (bus.flush) begin
                    state_d = bus.div_finish ? S_IDLE : S_DRAIN;
                end else if (bus.div_finish) begin
                    wb_data_d = bus.div_res;
                    wb_tag_d  = tag_q;
                    state_d   = S_WB;
                end
            end
            S_WB: begin
                wb_valid = !bus.flush;
                if (bus.flush || bus.wb_ready) begin
                    state_d = S_IDLE;
                end
            end
            S_DRAIN: begin
                if (bus.div_finish) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            rr_ptr_q  <= '0;
            a_q       <= '0;
            b_q       <= '0;
            tag_q     <= '0;
            wb_data_q <= '0;
            wb_tag_q  <= '0;
        end else begin
            state_q   <= state_d;
            rr_ptr_q  <= rr_ptr_d;
            a_q       <= a_d;
            b_q       <= b_d;
            tag_q     <= tag_d;
            wb_data_q <= wb_data_d;
            wb_tag_q  <= wb_tag_d;
        end
    end

    assign bus.req_grant = grant;
    assign bus.div_en    = div_en;
    assign bus.div_a     = a_q;
    assign bus.div_b     = b_q;
    assign bus.wb_valid  = wb_valid;
    assign bus.wb_tag    = wb_tag_q;
    assign bus.wb_data   = wb_data_q;
    assign bus.busy      = (state_q != S_IDLE);
endmodule

// File: tb/tb_fu_div_sched.sv
// tb/tb_fu_div_sched.sv - directed self-checking bench for fu_div_sched
module tb_fu_div_sched;
    localparam int L = 4;

    logic clk;
    logic rst;
    int   total;
    int   bad;
    int   fu_cnt;
    logic [31:0] fu_res;

    fu_div_sched_if #(.NREQ(4), .TAG_W(4), .DATA_W(32)) bus ();

    fu_div_sched #(.NREQ(4), .TAG_W(4), .DATA_W(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // FU_div stand-in: fixed latency, cannot abort, not reset with the scheduler.
    initial begin
        fu_cnt         = 0;
        fu_res         = '0;
        bus.div_finish = 1'b0;
        bus.div_res    = '0;
        forever begin
            @(negedge clk);
            bus.div_finish = 1'b0;
            if (fu_cnt != 0) begin
                fu_cnt = fu_cnt - 1;
                if (fu_cnt == 0) begin
                    bus.div_finish = 1'b1;
                    bus.div_res    = fu_res;
                end
            end
            if (bus.div_en) begin
                fu_cnt = L;
                fu_res = (bus.div_b == 0) ? 32'hDEAD0000 : bus.div_a / bus.div_b;
            end
        end
    end

    task automatic set_slot(input int s, input logic [31:0] a, input logic [31:0] b, input logic [3:0] tag);
        bus.req_a[s*32 +: 32] = a;
        bus.req_b[s*32 +: 32] = b;
        bus.req_tag[s*4 +: 4] = tag;
    endtask

    task automatic wait_wb(output int n);
        n = 0;
        while (!bus.wb_valid && n < 50) begin
            @(negedge clk); #1;
            n++;
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        @(negedge clk); #1;
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
        total++; if (bus.wb_valid !== 1'b0) begin bad++; $display("FAIL reset_wb_valid got=%b exp=0", bus.wb_valid); end
        total++; if (bus.div_en !== 1'b0) begin bad++; $display("FAIL reset_div_en got=%b exp=0", bus.div_en); end
        total++; if (bus.div_a !== 32'd0) begin bad++; $display("FAIL reset_div_a got=%h exp=0", bus.div_a); end
        total++; if (bus.wb_data !== 32'd0) begin bad++; $display("FAIL reset_wb_data got=%h exp=0", bus.wb_data); end
        rst = 1'b0;
        @(negedge clk); #1;
    endtask

    task automatic test_single_op;
        int n;
        set_slot(0, 32'd100, 32'd7, 4'd3);
        bus.req_valid = 4'b0001;
        #1;
        total++; if (bus.req_grant !== 4'b0001) begin bad++; $display("FAIL single_grant got=%b exp=0001", bus.req_grant); end
        @(negedge clk); #1;
        bus.req_valid = 4'b0000;
        total++; if (bus.div_en !== 1'b1) begin bad++; $display("FAIL single_div_en got=%b exp=1", bus.div_en); end
        total++; if (bus.div_a !== 32'd100) begin bad++; $display("FAIL single_div_a got=%0d exp=100", bus.div_a); end
        total++; if (bus.div_b !== 32'd7) begin bad++; $display("FAIL single_div_b got=%0d exp=7", bus.div_b); end
        wait_wb(n);
        total++; if (n !== L + 1) begin bad++; $display("FAIL single_latency got=%0d exp=%0d", n, L + 1); end
        total++; if (bus.wb_tag !== 4'd3) begin bad++; $display("FAIL single_wb_tag got=%0d exp=3", bus.wb_tag); end
        total++; if (bus.wb_data !== 32'd14) begin bad++; $display("FAIL single_wb_data got=%0d exp=14", bus.wb_data); end
        @(negedge clk); #1;
        total++; if (bus.wb_valid !== 1'b0) begin bad++; $display("FAIL single_wb_drop got=%b exp=0", bus.wb_valid); end
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL single_idle got=%b exp=0", bus.busy); end
    endtask

    task automatic test_fairness;
        int got, hs, cyc;
        logic [3:0]  exp_g;
        logic [31:0] q_exp [4];
        q_exp = '{32'd50, 32'd37, 32'd30, 32'd26};
        rst = 1'b1;
        @(negedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < 4; i++) set_slot(i, 32'(100 + i * 11), 32'(i + 2), 4'(8 + i));
        bus.req_valid = 4'b1111;
        #1;
        got = 0; hs = 0; cyc = 0;
        while (got < 5 && cyc < 200) begin
            if (bus.req_grant != 4'b0000) begin
                exp_g = 4'b0001 << (got % 4);
                total++; if (bus.req_grant !== exp_g) begin bad++; $display("FAIL rr_grant%0d got=%b exp=%b", got, bus.req_grant, exp_g); end
                if (got > 0) begin
                    total++; if (hs !== 1) begin bad++; $display("FAIL rr_handshakes%0d got=%0d exp=1", got, hs); end
                end
                hs = 0;
                got++;
            end
            if (bus.wb_valid && bus.wb_ready) begin
                total++; if (bus.wb_tag !== 4'(8 + (got - 1) % 4)) begin bad++; $display("FAIL rr_wb_tag got=%0d exp=%0d", bus.wb_tag, 8 + (got - 1) % 4); end
                total++; if (bus.wb_data !== q_exp[(got - 1) % 4]) begin bad++; $display("FAIL rr_wb_data got=%0d exp=%0d", bus.wb_data, q_exp[(got - 1) % 4]); end
                hs++;
            end
            @(negedge clk); #1;
            cyc++;
        end
        total++; if (got !== 5) begin bad++; $display("FAIL rr_grant_count got=%0d exp=5", got); end
        bus.req_valid = 4'b0000;
        cyc = 0;
        while (bus.busy && cyc < 50) begin
            @(negedge clk); #1;
            cyc++;
        end
    endtask

    task automatic test_backpressure;
        int n;
        logic stable_ok;
        bus.wb_ready = 1'b0;
        set_slot(2, 32'd1000, 32'd10, 4'd5);
        bus.req_valid = 4'b0100;
        #1;
        total++; if (bus.req_grant !== 4'b0100) begin bad++; $display("FAIL bp_grant got=%b exp=0100", bus.req_grant); end
        @(negedge clk); #1;
        bus.req_valid = 4'b0000;
        wait_wb(n);
        total++; if (n >= 50) begin bad++; $display("FAIL bp_wb_timeout got=%0d exp<50", n); end
        set_slot(0, 32'd9, 32'd3, 4'd1);
        bus.req_valid = 4'b0001;
        stable_ok = 1'b1;
        for (int i = 0; i < 5; i++) begin
            if (bus.wb_valid !== 1'b1 || bus.wb_tag !== 4'd5 || bus.wb_data !== 32'd100 || bus.req_grant !== 4'b0000)
                stable_ok = 1'b0;
            @(negedge clk); #1;
        end
        total++; if (stable_ok !== 1'b1) begin bad++; $display("FAIL bp_stable got=%b exp=1", stable_ok); end
        bus.wb_ready = 1'b1;
        #1;
        total++; if (bus.wb_valid !== 1'b1) begin bad++; $display("FAIL bp_accept_valid got=%b exp=1", bus.wb_valid); end
        @(negedge clk); #1;
        total++; if (bus.wb_valid !== 1'b0) begin bad++; $display("FAIL bp_wb_drop got=%b exp=0", bus.wb_valid); end
        total++; if (bus.req_grant !== 4'b0001) begin bad++; $display("FAIL bp_next_grant got=%b exp=0001", bus.req_grant); end
        @(negedge clk); #1;
        bus.req_valid = 4'b0000;
        wait_wb(n);
        total++; if (bus.wb_data !== 32'd3) begin bad++; $display("FAIL bp_next_data got=%0d exp=3", bus.wb_data); end
        total++; if (bus.wb_tag !== 4'd1) begin bad++; $display("FAIL bp_next_tag got=%0d exp=1", bus.wb_tag); end
        @(negedge clk); #1;
    endtask

    task automatic test_flush;
        int n;
        logic quiet;
        bus.flush = 1'b1;
        set_slot(1, 32'd50, 32'd5, 4'd7);
        bus.req_valid = 4'b0010;
        #1;
        total++; if (bus.req_grant !== 4'b0000) begin bad++; $display("FAIL flush_idle_grant got=%b exp=0000", bus.req_grant); end
        @(negedge clk); #1;
        bus.flush = 1'b0;
        #1;
        total++; if (bus.req_grant !== 4'b0010) begin bad++; $display("FAIL flush_release_grant got=%b exp=0010", bus.req_grant); end
        @(negedge clk); #1;
        bus.req_valid = 4'b0000;
        total++; if (bus.div_en !== 1'b1) begin bad++; $display("FAIL flush_div_en got=%b exp=1", bus.div_en); end
        @(negedge clk); #1;
        bus.flush = 1'b1;
        set_slot(3, 32'd81, 32'd9, 4'd2);
        bus.req_valid = 4'b1000;
        @(negedge clk); #1;
        bus.flush = 1'b0;
        n = 1;
        quiet = 1'b1;
        #1;
        while (bus.req_grant == 4'b0000 && n < 20) begin
            if (bus.wb_valid || bus.div_en || !bus.busy) quiet = 1'b0;
            @(negedge clk); #1;
            n++;
        end
        total++; if (quiet !== 1'b1) begin bad++; $display("FAIL drain_quiet got=%b exp=1", quiet); end
        total++; if (n !== 4) begin bad++; $display("FAIL drain_regrant_cycle got=%0d exp=4", n); end
        total++; if (bus.req_grant !== 4'b1000) begin bad++; $display("FAIL drain_regrant got=%b exp=1000", bus.req_grant); end
        @(negedge clk); #1;
        bus.req_valid = 4'b0000;
        wait_wb(n);
        total++; if (bus.wb_data !== 32'd9) begin bad++; $display("FAIL drain_next_data got=%0d exp=9", bus.wb_data); end
        total++; if (bus.wb_tag !== 4'd2) begin bad++; $display("FAIL drain_next_tag got=%0d exp=2", bus.wb_tag); end
        @(negedge clk); #1;
    endtask

    task automatic test_async_reset;
        int n;
        logic idle_ok;
        set_slot(0, 32'd60, 32'd6, 4'd4);
        bus.req_valid = 4'b0001;
        @(negedge clk); #1;
        bus.req_valid = 4'b0000;
        @(negedge clk); #1;
        #2 rst = 1'b1;
        #1;
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL arst_busy got=%b exp=0", bus.busy); end
        total++; if (bus.div_a !== 32'd0) begin bad++; $display("FAIL arst_div_a got=%h exp=0", bus.div_a); end
        total++; if (bus.wb_data !== 32'd0) begin bad++; $display("FAIL arst_wb_data got=%h exp=0", bus.wb_data); end
        @(negedge clk); #1;
        rst = 1'b0;
        idle_ok = 1'b1;
        for (int i = 0; i < 6; i++) begin
            if (bus.busy !== 1'b0 || bus.wb_valid !== 1'b0) idle_ok = 1'b0;
            @(negedge clk); #1;
        end
        total++; if (idle_ok !== 1'b1) begin bad++; $display("FAIL arst_stale_finish got=%b exp=1", idle_ok); end
        set_slot(0, 32'd77, 32'd7, 4'd9);
        set_slot(2, 32'd1, 32'd1, 4'd1);
        bus.req_valid = 4'b0101;
        #1;
        total++; if (bus.req_grant !== 4'b0001) begin bad++; $display("FAIL arst_rr_restart got=%b exp=0001", bus.req_grant); end
        @(negedge clk); #1;
        bus.req_valid = 4'b0000;
        wait_wb(n);
        total++; if (bus.wb_data !== 32'd11) begin bad++; $display("FAIL arst_wb_data_after got=%0d exp=11", bus.wb_data); end
        total++; if (bus.wb_tag !== 4'd9) begin bad++; $display("FAIL arst_wb_tag_after got=%0d exp=9", bus.wb_tag); end
        @(negedge clk); #1;
    endtask

    task automatic test_div_zero;
        int n;
        set_slot(1, 32'd5, 32'd0, 4'd6);
        bus.req_valid = 4'b0010;
        #1;
        total++; if (bus.req_grant !== 4'b0010) begin bad++; $display("FAIL dz_grant got=%b exp=0010", bus.req_grant); end
        @(negedge clk); #1;
        bus.req_valid = 4'b0000;
`ifdef DIV_ZERO_BYPASS_EN
        total++; if (bus.div_en !== 1'b0) begin bad++; $display("FAIL dz_div_en got=%b exp=0", bus.div_en); end
        total++; if (bus.wb_valid !== 1'b1) begin bad++; $display("FAIL dz_wb_valid got=%b exp=1", bus.wb_valid); end
        total++; if (bus.wb_data !== 32'hFFFFFFFF) begin bad++; $display("FAIL dz_wb_data got=%h exp=ffffffff", bus.wb_data); end
`else
        total++; if (bus.div_en !== 1'b1) begin bad++; $display("FAIL dz_div_en got=%b exp=1", bus.div_en); end
        wait_wb(n);
        total++; if (n !== L + 1) begin bad++; $display("FAIL dz_latency got=%0d exp=%0d", n, L + 1); end
        total++; if (bus.wb_data !== 32'hDEAD0000) begin bad++; $display("FAIL dz_wb_data got=%h exp=dead0000", bus.wb_data); end
`endif
        total++; if (bus.wb_tag !== 4'd6) begin bad++; $display("FAIL dz_wb_tag got=%0d exp=6", bus.wb_tag); end
        @(negedge clk); #1;
    endtask

    initial begin
        total         = 0;
        bad           = 0;
        rst           = 1'b1;
        bus.req_valid = '0;
        bus.req_a     = '0;
        bus.req_b     = '0;
        bus.req_tag   = '0;
        bus.flush     = 1'b0;
        bus.wb_ready  = 1'b1;
        test_reset();
        test_single_op();
        test_fairness();
        test_backpressure();
        test_flush();
        test_async_reset();
        test_div_zero();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
